// File: rtl/eth_kv_map_loader.sv
// Programs one transport-adapter RX key-value map entry per handshake: polls the
// KV busy flag over the register port, then issues the five KV writes ending with CFG.
module eth_kv_map_loader #(
  parameter int                    REG_AWIDTH     = 14,
  parameter logic [REG_AWIDTH-1:0] ADDR_KV_MAC_LO = 14'h1010,
  parameter logic [REG_AWIDTH-1:0] ADDR_KV_MAC_HI = 14'h1014,
  parameter logic [REG_AWIDTH-1:0] ADDR_KV_IP     = 14'h1018,
  parameter logic [REG_AWIDTH-1:0] ADDR_KV_UDP    = 14'h101C,
  parameter logic [REG_AWIDTH-1:0] ADDR_KV_CFG    = 14'h1020,
  parameter int                    POLL_MAX       = 1024,
  parameter int                    RD_TIMEOUT     = 16
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [47:0]           s_mac,
  input  logic [31:0]           s_ip,
  input  logic [15:0]           s_udp,
  input  logic [15:0]           s_epid,
  input  logic                  s_raw_udp,
  output logic                  reg_wr_req,
  output logic [REG_AWIDTH-1:0] reg_wr_addr,
  output logic [31:0]           reg_wr_data,
  output logic                  reg_rd_req,
  output logic [REG_AWIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_resp,
  input  logic [31:0]           reg_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           entry_count,
  output logic [15:0]           err_count
);

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int TCW = $clog2(RD_TIMEOUT);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, POLL_REQ, POLL_WAIT, WR_MAC_LO, WR_MAC_HI, WR_IP, WR_UDP, WR_CFG
  } state_t;

  state_t          state_reg, state_next;
  logic [PCW-1:0]  poll_cnt_reg, poll_cnt_next;
  logic [TCW-1:0]  timer_reg, timer_next;
  logic [47:0]     mac_reg;
  logic [31:0]     ip_reg;
  logic [15:0]     udp_reg, epid_reg;
  logic            raw_reg;
  logic            take, abort;

  logic                  s_ready_reg, s_ready_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  wr_req_reg, wr_req_next;
  logic [REG_AWIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [31:0]           wr_data_reg, wr_data_next;
  logic                  rd_req_reg, rd_req_next;
  logic [REG_AWIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic [15:0]           entry_cnt_reg, entry_cnt_next;
  logic [15:0]           err_cnt_reg, err_cnt_next;

  // Only the busy flag of the CFG readback matters.
  logic unused_rd_bits;
  assign unused_rd_bits = ^reg_rd_data[30:0];

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_reg     <= IDLE;
      poll_cnt_reg  <= '0;
      timer_reg     <= '0;
      mac_reg       <= '0;
      ip_reg        <= '0;
      udp_reg       <= '0;
      epid_reg      <= '0;
      raw_reg       <= 1'b0;
      s_ready_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      wr_req_reg    <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      rd_req_reg    <= 1'b0;
      rd_addr_reg   <= '0;
      entry_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      poll_cnt_reg  <= poll_cnt_next;
      timer_reg     <= timer_next;
      if (take) begin
        mac_reg  <= s_mac;
        ip_reg   <= s_ip;
        udp_reg  <= s_udp;
        epid_reg <= s_epid;
        raw_reg  <= s_raw_udp;
      end
      s_ready_reg   <= s_ready_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      wr_req_reg    <= wr_req_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      rd_req_reg    <= rd_req_next;
      rd_addr_reg   <= rd_addr_next;
      entry_cnt_reg <= entry_cnt_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    poll_cnt_next = poll_cnt_reg;
    timer_next    = timer_reg;
    take          = 1'b0;
    abort         = 1'b0;
    case (state_reg)
      IDLE: begin
        // s_ready is registered, so the first cycle after reset refuses entries.
        if (s_valid && s_ready_reg) begin
          take          = 1'b1;
          poll_cnt_next = '0;
          state_next    = POLL_REQ;
        end
      end
      POLL_REQ: begin
        poll_cnt_next = poll_cnt_reg + PCW'(1);
        timer_next    = '0;
        state_next    = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (reg_rd_resp) begin
          if (!reg_rd_data[31])            state_next = WR_MAC_LO;
          else if (poll_cnt_reg == POLL_LAST) abort = 1'b1;
          else                             state_next = POLL_REQ;
        end else if (timer_reg == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          timer_next = timer_reg + TCW'(1);
        end
        if (abort) state_next = IDLE;
      end
      WR_MAC_LO: state_next = WR_MAC_HI;
      WR_MAC_HI: state_next = WR_IP;
      WR_IP:     state_next = WR_UDP;
      WR_UDP:    state_next = WR_CFG;
      WR_CFG:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state will present.
  always_comb begin
    s_ready_next = (state_next == IDLE);
    busy_next    = (state_next != IDLE);
    done_next    = (state_reg == WR_CFG);
    err_next     = abort;
    rd_req_next  = (state_next == POLL_REQ);
    rd_addr_next = rd_req_next ? ADDR_KV_CFG : rd_addr_reg;
    wr_req_next  = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    case (state_next)
      WR_MAC_LO: begin
        wr_req_next  = 1'b1;
        wr_addr_next = ADDR_KV_MAC_LO;
        wr_data_next = mac_reg[31:0];
      end
      WR_MAC_HI: begin
        wr_req_next  = 1'b1;
        wr_addr_next = ADDR_KV_MAC_HI;
        wr_data_next = {16'b0, mac_reg[47:32]};
      end
      WR_IP: begin
        wr_req_next  = 1'b1;
        wr_addr_next = ADDR_KV_IP;
        wr_data_next = ip_reg;
      end
      WR_UDP: begin
        wr_req_next  = 1'b1;
        wr_addr_next = ADDR_KV_UDP;
        wr_data_next = {16'b0, udp_reg};
      end
      WR_CFG: begin
        wr_req_next  = 1'b1;
        wr_addr_next = ADDR_KV_CFG;
        wr_data_next = {15'b0, raw_reg, epid_reg};
      end
      default: ;
    endcase
    entry_cnt_next = entry_cnt_reg + 16'(done_next);
    err_cnt_next   = (err_next && (err_cnt_reg != 16'hFFFF)) ? err_cnt_reg + 16'd1 : err_cnt_reg;
  end

  assign s_ready     = s_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign reg_wr_req  = wr_req_reg;
  assign reg_wr_addr = wr_addr_reg;
  assign reg_wr_data = wr_data_reg;
  assign reg_rd_req  = rd_req_reg;
  assign reg_rd_addr = rd_addr_reg;
  assign entry_count = entry_cnt_reg;
  assign err_count   = err_cnt_reg;

endmodule

// File: tb/tb_eth_kv_map_loader.sv
// Scoreboard bench for eth_kv_map_loader: stimulus queues expected register-port
// events and state checks; a negedge monitor pops and compares them.
module tb_eth_kv_map_loader;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [47:0] s_mac;
  logic [31:0] s_ip;
  logic [15:0] s_udp;
  logic [15:0] s_epid;
  logic        s_raw_udp;
  logic        reg_wr_req;
  logic [13:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        reg_rd_req;
  logic [13:0] reg_rd_addr;
  logic        reg_rd_resp;
  logic [31:0] reg_rd_data;
  logic        busy, done, err;
  logic [15:0] entry_count, err_count;

  eth_kv_map_loader #(.POLL_MAX(4), .RD_TIMEOUT(16)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_mac(s_mac), .s_ip(s_ip),
    .s_udp(s_udp), .s_epid(s_epid), .s_raw_udp(s_raw_udp),
    .reg_wr_req(reg_wr_req), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
    .reg_rd_resp(reg_rd_resp), .reg_rd_data(reg_rd_data),
    .busy(busy), .done(done), .err(err),
    .entry_count(entry_count), .err_count(err_count)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct { int kind; logic [13:0] addr; logic [31:0] data; int cyc; } ev_t;
  typedef struct { string name; int id; logic [31:0] exp; logic [31:0] act; } chk_t;

  localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;
  localparam int C_OUTS = 0, C_READY = 1, C_BUSY = 2, C_ECNT = 3, C_XCNT = 4, C_QEMPTY = 5, C_TMO = 6;

  ev_t  exp_q[$];
  chk_t chk_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge bus_clk) cyc <= cyc + 1;

  // Register responder: answers each read one cycle later; busy for the first busy_polls reads.
  int busy_polls = 0;
  bit silent = 1'b0;
  bit spur = 1'b0;
  int poll_idx;
  always @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      reg_rd_resp <= 1'b0;
      reg_rd_data <= '0;
      poll_idx    <= 0;
    end else begin
      reg_rd_resp <= 1'b0;
      reg_rd_data <= '0;
      if (s_valid && s_ready) poll_idx <= 0;
      if (reg_rd_req && !silent) begin
        reg_rd_resp <= 1'b1;
        reg_rd_data <= (poll_idx < busy_polls) ? 32'h8000_00FF : 32'h0000_1234;
        poll_idx    <= poll_idx + 1;
      end
      if (spur) begin
        reg_rd_resp <= 1'b1;
        reg_rd_data <= 32'h0;
      end
    end
  end

  function automatic void push_ev(int k, logic [13:0] a, logic [31:0] d, int c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  function automatic void push_chk(string n, int id, logic [31:0] ex, logic [31:0] act = 32'h0);
    chk_t c;
    c.name = n; c.id = id; c.exp = ex; c.act = act;
    chk_q.push_back(c);
  endfunction

  function automatic void push_writes(logic [47:0] m, logic [31:0] ip, logic [15:0] u,
                                      logic [15:0] ep, logic r, int c0);
    push_ev(K_WR, 14'h1010, m[31:0], c0);
    push_ev(K_WR, 14'h1014, {16'h0, m[47:32]}, c0 + 1);
    push_ev(K_WR, 14'h1018, ip, c0 + 2);
    push_ev(K_WR, 14'h101C, {16'h0, u}, c0 + 3);
    push_ev(K_WR, 14'h1020, {15'h0, r, ep}, c0 + 4);
  endfunction

  function automatic string kname(int k);
    case (k)
      K_RD:    return "read";
      K_WR:    return "write";
      K_DONE:  return "done";
      default: return "err";
    endcase
  endfunction

  function automatic logic [31:0] chk_act(int id, logic [31:0] tbv);
    case (id)
      C_OUTS:   return {21'b0, s_ready, busy, done, err, reg_wr_req, reg_rd_req,
                        |reg_wr_addr, |reg_wr_data, |reg_rd_addr, |entry_count, |err_count};
      C_READY:  return {31'b0, s_ready};
      C_BUSY:   return {31'b0, busy};
      C_ECNT:   return {16'b0, entry_count};
      C_XCNT:   return {16'b0, err_count};
      C_QEMPTY: return 32'(exp_q.size());
      default:  return tbv;
    endcase
  endfunction

  task automatic check_ev(int k, logic [13:0] a, logic [31:0] d);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got addr=%h data=%h at cycle %0d, want no event", kname(k), a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d || (e.cyc >= 0 && e.cyc != cyc)) begin
        miscompares++;
        $display("FAIL event_%s: got %s addr=%h data=%h cycle=%0d, want %s addr=%h data=%h cycle=%0d",
                 kname(e.kind), kname(k), a, d, cyc, kname(e.kind), e.addr, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge bus_clk) begin
    chk_t c;
    logic [31:0] act;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      act = chk_act(c.id, c.act);
      vectors++;
      if (act !== c.exp) begin
        miscompares++;
        $display("FAIL %s: got %h, want %h (cycle %0d)", c.name, act, c.exp, cyc);
      end
    end
    if (bus_rst_n) begin
      if (reg_rd_req || reg_wr_req) begin
        vectors++;
        if (reg_rd_req && reg_wr_req) begin
          miscompares++;
          $display("FAIL strobe_overlap: got rd=1 wr=1 at cycle %0d, want at most one", cyc);
        end
      end
      if (done || err) begin
        vectors++;
        if (done && err) begin
          miscompares++;
          $display("FAIL done_err_overlap: got done=1 err=1 at cycle %0d, want at most one", cyc);
        end
      end
      if (reg_rd_req) check_ev(K_RD, reg_rd_addr, 32'h0);
      if (reg_wr_req) check_ev(K_WR, reg_wr_addr, reg_wr_data);
      if (done)       check_ev(K_DONE, 14'h0, {16'h0, entry_count});
      if (err)        check_ev(K_ERR, 14'h0, {16'h0, err_count});
    end
  end

  task automatic tick;
    @(negedge bus_clk);
    #1;
  endtask

  task automatic send(input logic [47:0] m, input logic [31:0] ip, input logic [15:0] u,
                      input logic [15:0] ep, input logic r, output int hs);
    s_mac = m; s_ip = ip; s_udp = u; s_epid = ep; s_raw_udp = r; s_valid = 1'b1;
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      if (s_ready) begin
        hs = cyc;
        break;
      end
      tick;
    end
    if (hs < 0) push_chk("handshake_wait", C_TMO, 32'h0, 32'h1);
  endtask

  task automatic wait_ready(input string n);
    tick;
    for (int i = 0; i < 100 && !s_ready; i++) tick;
    if (!s_ready) push_chk(n, C_TMO, 32'h0, 32'h1);
  endtask

  task automatic scramble;
    s_valid = 1'b0; s_mac = '1; s_ip = '1; s_udp = '1; s_epid = '1; s_raw_udp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, want completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h0, base;
    bus_rst_n = 1'b0;
    s_valid = 1'b0; s_mac = '0; s_ip = '0; s_udp = '0; s_epid = '0; s_raw_udp = 1'b0;
    push_chk("reset_outputs", C_OUTS, 32'h0);
    tick; tick;
    bus_rst_n = 1'b1;
    push_chk("ready_after_reset", C_READY, 32'h1);
    tick;

    // Single entry, idle responder: hand-computed register image.
    busy_polls = 0;
    send(48'h00802F16C530, 32'hC0A80A05, 16'hC001, 16'h0042, 1'b1, h);
    push_ev(K_RD, 14'h1020, 32'h0, h + 1);
    push_ev(K_WR, 14'h1010, 32'h2F16C530, h + 3);
    push_ev(K_WR, 14'h1014, 32'h00000080, h + 4);
    push_ev(K_WR, 14'h1018, 32'hC0A80A05, h + 5);
    push_ev(K_WR, 14'h101C, 32'h0000C001, h + 6);
    push_ev(K_WR, 14'h1020, 32'h00010042, h + 7);
    push_ev(K_DONE, 14'h0, 32'd1, h + 8);
    tick; scramble;
    wait_ready("single_wait");
    push_chk("single_entry_count", C_ECNT, 32'd1);
    push_chk("single_drained", C_QEMPTY, 32'd0);
    tick;

    // Busy for three polls, then clear.
    busy_polls = 3;
    send(48'hA1B2C3D4E5F6, 32'h0A000001, 16'h1234, 16'h0007, 1'b0, h);
    for (int i = 0; i < 4; i++) push_ev(K_RD, 14'h1020, 32'h0, h + 1 + 2 * i);
    push_ev(K_WR, 14'h1010, 32'hC3D4E5F6, h + 9);
    push_ev(K_WR, 14'h1014, 32'h0000A1B2, h + 10);
    push_ev(K_WR, 14'h1018, 32'h0A000001, h + 11);
    push_ev(K_WR, 14'h101C, 32'h00001234, h + 12);
    push_ev(K_WR, 14'h1020, 32'h00000007, h + 13);
    push_ev(K_DONE, 14'h0, 32'd2, h + 14);
    tick; scramble;
    wait_ready("busy_poll_wait");
    push_chk("busy_poll_entry_count", C_ECNT, 32'd2);
    push_chk("busy_poll_drained", C_QEMPTY, 32'd0);
    tick;

    // Busy forever: POLL_MAX reads, then abort with no writes.
    busy_polls = 1000;
    send(48'h111122223333, 32'h01020304, 16'h0050, 16'h0099, 1'b1, h);
    for (int i = 0; i < 4; i++) push_ev(K_RD, 14'h1020, 32'h0, h + 1 + 2 * i);
    push_ev(K_ERR, 14'h0, 32'd1, h + 9);
    tick; scramble;
    wait_ready("busy_forever_wait");
    push_chk("busy_forever_err_count", C_XCNT, 32'd1);
    push_chk("busy_forever_ready", C_READY, 32'd1);
    push_chk("busy_forever_entry_count", C_ECNT, 32'd2);
    push_chk("busy_forever_drained", C_QEMPTY, 32'd0);
    tick;

    // Silent responder: timeout abort, then a stray response in IDLE.
    silent = 1'b1;
    busy_polls = 0;
    send(48'h444455556666, 32'h05060708, 16'h0051, 16'h0098, 1'b0, h);
    push_ev(K_RD, 14'h1020, 32'h0, h + 1);
    push_ev(K_ERR, 14'h0, 32'd2, h + 18);
    tick; scramble;
    wait_ready("timeout_wait");
    silent = 1'b0;
    spur = 1'b1;
    tick;
    spur = 1'b0;
    repeat (4) tick;
    push_chk("spurious_busy", C_BUSY, 32'd0);
    push_chk("timeout_err_count", C_XCNT, 32'd2);
    push_chk("timeout_drained", C_QEMPTY, 32'd0);
    tick;

    // Reset during WR_IP: UDP/CFG never issued, next entry completes.
    send(48'h0A0B0C0D0E0F, 32'hAC100001, 16'h2710, 16'h0011, 1'b1, h);
    push_ev(K_RD, 14'h1020, 32'h0, h + 1);
    push_ev(K_WR, 14'h1010, 32'h0C0D0E0F, h + 3);
    push_ev(K_WR, 14'h1014, 32'h00000A0B, h + 4);
    push_ev(K_WR, 14'h1018, 32'hAC100001, h + 5);
    tick; scramble;
    for (int i = 0; i < 50 && cyc < h + 5; i++) tick;
    bus_rst_n = 1'b0;
    push_chk("mid_reset_outputs", C_OUTS, 32'h0);
    push_chk("mid_reset_drained", C_QEMPTY, 32'd0);
    tick;
    bus_rst_n = 1'b1;
    tick;
    send(48'h665544332211, 32'hC0000201, 16'hBEEF, 16'h0123, 1'b0, h);
    push_ev(K_RD, 14'h1020, 32'h0, h + 1);
    push_writes(48'h665544332211, 32'hC0000201, 16'hBEEF, 16'h0123, 1'b0, h + 3);
    push_ev(K_DONE, 14'h0, 32'd1, h + 8);
    tick; scramble;
    wait_ready("after_reset_wait");
    push_chk("after_reset_entry_count", C_ECNT, 32'd1);
    push_chk("after_reset_err_count", C_XCNT, 32'd0);
    push_chk("after_reset_drained", C_QEMPTY, 32'd0);
    tick;

    // Back-to-back stream of 20 with s_valid held high: one entry per 8 cycles.
    bus_rst_n = 1'b0;
    tick;
    bus_rst_n = 1'b1;
    tick;
    h0 = 0;
    for (int i = 0; i < 20; i++) begin
      send(48'h020000000000 + 48'(i), 32'hC0A80100 + 32'(i), 16'h1000 + 16'(i),
           16'(i), i[0], h);
      if (i == 0) h0 = h;
      base = h0 + 8 * i;
      push_ev(K_RD, 14'h1020, 32'h0, base + 1);
      push_writes(48'h020000000000 + 48'(i), 32'hC0A80100 + 32'(i), 16'h1000 + 16'(i),
                  16'(i), i[0], base + 3);
      push_ev(K_DONE, 14'h0, 32'(i + 1), base + 8);
      tick;
    end
    scramble;
    wait_ready("stream_wait");
    push_chk("stream_entry_count", C_ECNT, 32'd20);
    push_chk("stream_drained", C_QEMPTY, 32'd0);
    repeat (3) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
